alu_scheduler: RTL and testbench
================================

ALU_SCHEDULER -- requirements
Module: alu_scheduler

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have ports req0, req1  input  1 each  operation request from requester 0/1.
REQ-005 The block SHALL have ports a0, b0, a1, b1  input  WIDTH each  operands of requester 0/1.
REQ-006 The block SHALL have ports c0, c1  input  1 each  carry-in of requester 0/1.
REQ-007 The block SHALL have ports func0, func1  input  3 each  ALU function code of requester 0/1.
REQ-008 The block SHALL have ports ack0, ack1  output  1 each  one-cycle request-accepted pulse.
REQ-009 The block SHALL have ports alu_a, alu_b  output  WIDTH each  registered operands driven to the shared ALU.
REQ-010 The block SHALL have ports alu_c  output  1 and alu_func  output  3  registered carry and function to the ALU.
REQ-011 The block SHALL have ports alu_w  input  WIDTH, alu_zer  input  1, alu_neg  input  1  combinational ALU result.
REQ-012 The block SHALL have ports res_w  output  WIDTH, res_zer  output  1, res_neg  output  1  captured result.
REQ-013 The block SHALL have ports res_valid  output  1, res_id  output  1 (owning requester), res_ready  input  1 (consumer accepts).
REQ-014 The block SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, DONE.
REQ-016 IDLE with neither req SHALL remain IDLE with all outputs held.
REQ-017 IDLE with any req SHALL, on the next edge: select a winner, register its a/b/c/func into alu_a/alu_b/alu_c/alu_func, set res_id to the winner, assert the winner's ack, and move to EXEC.
REQ-018 Arbitration SHALL be round-robin: a single requesting side wins; if both request, the side not granted last wins; last-grant SHALL update on every grant.
REQ-019 ack0/ack1 SHALL be high for exactly the EXEC cycle, never both, and never outside EXEC.
REQ-020 EXEC SHALL last exactly one cycle; on its closing edge alu_w/alu_zer/alu_neg SHALL be captured into res_w/res_zer/res_neg, res_valid set to 1, and the state SHALL move to DONE.
REQ-021 Latency SHALL be 2 cycles from the edge sampling req to res_valid high.
REQ-022 DONE SHALL hold res_valid and all res_* stable until an edge with res_ready=1, then clear res_valid and return to IDLE.
REQ-023 res_ready while res_valid=0 SHALL be ignored.
REQ-024 Requests and operand changes during EXEC or DONE SHALL be ignored; a held req is sampled again in the next IDLE, giving a minimum of 3 cycles per operation.
REQ-025 A requester SHALL keep req and operands stable until its ack; the block SHALL sample operands only on the IDLE grant edge.
REQ-026 alu_a/alu_b/alu_c/alu_func SHALL hold their last granted values outside the grant edge.
REQ-027 busy SHALL be a decode of state (0 in IDLE, 1 in EXEC and DONE).

Reset
REQ-028 rst_n=0 SHALL immediately, without a clock edge, force state IDLE, ack0=ack1=0, res_valid=0, res_id=0, res_w/alu_a/alu_b=0, res_zer=res_neg=alu_c=0, alu_func=0, and last-grant=1 so requester 0 wins the first contention.
REQ-029 Reset asserted in EXEC or DONE SHALL discard the in-flight operation; no ack or res_valid SHALL appear for it after release.
REQ-030 After rst_n rises, the first grant SHALL occur no earlier than the first clk edge with rst_n=1.

Verification
REQ-031 Bench ALU stub: w = a ^ b, zer = (w==0), neg = w[WIDTH-1].
REQ-032 Single request: req0=1, a0=16'h00F0, b0=16'h0F00 -> ack0 high 1 cycle after the grant edge; res_valid after 2 cycles, res_w=16'h0FF0, zer=0, neg=0, res_id=0.
REQ-033 Contention from reset: req0=req1=1 held -> grant order 0,1,0,1, ack0/ack1 alternating, each result held until res_ready.
REQ-034 Backpressure: res_ready=0 for 5 cycles with a result pending -> res_valid and res_* stable for all 5 cycles, no new ack; on res_ready=1, IDLE next cycle.
REQ-035 Flags: a1=16'h8000, b1=16'h0000 -> res_neg=1; a1=b1=16'h1234 -> res_w=0, res_zer=1.
REQ-036 Reset mid-op: assert rst_n=0 during EXEC -> all outputs 0 asynchronously; no res_valid after release until a new req.

Source files
------------

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin front end that lets two requesters share one
// combinational ALU. An operation takes one grant cycle (IDLE), one execute
// cycle (EXEC) and then waits in DONE until the consumer accepts the result.
module alu_scheduler #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // requester 0
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             c0,
    input  logic [2:0]       func0,
    output logic             ack0,
    // requester 1
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    input  logic             c1,
    input  logic [2:0]       func1,
    output logic             ack1,
    // shared ALU
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_c,
    output logic [2:0]       alu_func,
    input  logic [WIDTH-1:0] alu_w,
    input  logic             alu_zer,
    input  logic             alu_neg,
    // result
    output logic [WIDTH-1:0] res_w,
    output logic             res_zer,
    output logic             res_neg,
    output logic             res_valid,
    output logic             res_id,
    input  logic             res_ready,
    output logic             busy
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StDone
    } state_e;

    state_e           state_q;
    logic             last_q;       // requester granted most recently
    logic             ack0_q;
    logic             ack1_q;
    logic [WIDTH-1:0] alu_a_q;
    logic [WIDTH-1:0] alu_b_q;
    logic             alu_c_q;
    logic [2:0]       alu_func_q;
    logic [WIDTH-1:0] res_w_q;
    logic             res_zer_q;
    logic             res_neg_q;
    logic             res_valid_q;
    logic             res_id_q;

    // Winner: requester 1 when it asks alone, or when both ask and 0 went last.
    logic winner;
    assign winner = req1 & (~req0 | ~last_q);

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;  // requester 0 wins the first contention
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_c_q     <= 1'b0;
            alu_func_q  <= 3'd0;
            res_w_q     <= '0;
            res_zer_q   <= 1'b0;
            res_neg_q   <= 1'b0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req0 || req1) begin
                        alu_a_q    <= winner ? a1 : a0;
                        alu_b_q    <= winner ? b1 : b0;
                        alu_c_q    <= winner ? c1 : c0;
                        alu_func_q <= winner ? func1 : func0;
                        res_id_q   <= winner;
                        last_q     <= winner;
                        ack0_q     <= ~winner;
                        ack1_q     <= winner;
                        state_q    <= StExec;
                    end
                end
                StExec: begin
                    ack0_q      <= 1'b0;
                    ack1_q      <= 1'b0;
                    res_w_q     <= alu_w;
                    res_zer_q   <= alu_zer;
                    res_neg_q   <= alu_neg;
                    res_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // busy is a pure decode of the state register.
    always_comb begin
        busy = (state_q != StIdle);
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_c     = alu_c_q;
    assign alu_func  = alu_func_q;
    assign res_w     = res_w_q;
    assign res_zer   = res_zer_q;
    assign res_neg   = res_neg_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;

endmodule

// File: tb/tb_alu_scheduler.sv
// Self-checking bench for alu_scheduler: XOR ALU stub, expected results are
// queued when a request is driven and compared when res_valid rises.
module tb_alu_scheduler;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1, c0, c1, ack0, ack1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [2:0]       func0, func1;
    logic [WIDTH-1:0] alu_a, alu_b, alu_w, res_w;
    logic             alu_c, alu_zer, alu_neg;
    logic [2:0]       alu_func;
    logic             res_zer, res_neg, res_valid, res_id, res_ready, busy;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] w;
        logic             zer;
        logic             neg;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;

    // ALU stub
    always_comb begin
        alu_w   = alu_a ^ alu_b;
        alu_zer = (alu_w == '0);
        alu_neg = alu_w[WIDTH-1];
    end

    alu_scheduler #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .c0(c0), .func0(func0), .ack0(ack0),
        .req1(req1), .a1(a1), .b1(b1), .c1(c1), .func1(func1), .ack1(ack1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_func(alu_func),
        .alu_w(alu_w), .alu_zer(alu_zer), .alu_neg(alu_neg),
        .res_w(res_w), .res_zer(res_zer), .res_neg(res_neg),
        .res_valid(res_valid), .res_id(res_id), .res_ready(res_ready), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk_exp(input logic id, input logic [WIDTH-1:0] a,
                                    input logic [WIDTH-1:0] b);
        exp_t e;
        e.id  = id;
        e.w   = a ^ b;
        e.zer = ((a ^ b) == '0);
        e.neg = e.w[WIDTH-1];
        return e;
    endfunction

    // Result monitor: pops one expectation per rising res_valid.
    always @(negedge clk) begin
        if (res_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("res_w", res_w, e.w);
                check("res_zer", res_zer, e.zer);
                check("res_neg", res_neg, e.neg);
                check("res_id", res_id, e.id);
            end
        end
        prev_valid = res_valid;
    end

    // Waits for the grant, then walks the result through backpressure and acceptance.
    task automatic run_txn(input logic exp_id, input logic [WIDTH-1:0] exp_w,
                           input int stall, input bit drop);
        bit seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack0 || ack1) begin
                seen = 1;
                break;
            end
        end
        check("ack_seen", 32'(seen), 32'd1);
        check("ack_id", 32'(ack1), 32'(exp_id));
        check("ack_both", 32'(ack0 & ack1), 32'd0);
        check("busy_exec", 32'(busy), 32'd1);
        if (drop) begin
            // release the request and scramble operands; result must not change
            if (exp_id) begin req1 = 1'b0; a1 = 16'hDEAD; end
            else        begin req0 = 1'b0; a0 = 16'hBEEF; end
        end
        @(negedge clk);
        check("latency_valid", 32'(res_valid), 32'd1);
        check("ack_one_cycle", 32'(ack0 | ack1), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check("stall_valid", 32'(res_valid), 32'd1);
            check("stall_w", res_w, exp_w);
            check("stall_noack", 32'(ack0 | ack1), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("valid_cleared", 32'(res_valid), 32'd0);
        check("idle_after_ready", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        {req0, req1, c0, c1, res_ready} = '0;
        {a0, b0, a1, b1} = '0;
        func0 = 3'd0;
        func1 = 3'd0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ack", 32'({ack0, ack1}), 32'd0);
        check("rst_valid", 32'(res_valid), 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_func", 32'(alu_func), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // res_ready while idle is ignored
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_ready_ignored", 32'({busy, res_valid}), 32'd0);
        res_ready = 1'b0;

        // single request from requester 0
        a0 = 16'h00F0; b0 = 16'h0F00; c0 = 1'b1; func0 = 3'd5; req0 = 1'b1;
        exp_q.push_back(mk_exp(1'b0, 16'h00F0, 16'h0F00));
        @(negedge clk);
        check("grant_ack0", 32'(ack0), 32'd1);
        check("grant_alu_a", alu_a, 32'h00F0);
        check("grant_alu_b", alu_b, 32'h0F00);
        check("grant_alu_c", 32'(alu_c), 32'd1);
        check("grant_func", 32'(alu_func), 32'd5);
        req0 = 1'b0; a0 = 16'h1111;
        @(negedge clk);
        check("single_valid", 32'(res_valid), 32'd1);
        check("alu_hold", alu_a, 32'h00F0);
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("single_idle", 32'(busy), 32'd0);

        // contention from reset: 0,1,0,1 with one backpressured result
        do_reset();
        a0 = 16'h00F0; b0 = 16'h0F00; a1 = 16'h8000; b1 = 16'h0000;
        c1 = 1'b0; func1 = 3'd2;
        req0 = 1'b1; req1 = 1'b1;
        exp_q.push_back(mk_exp(1'b0, 16'h00F0, 16'h0F00));
        exp_q.push_back(mk_exp(1'b1, 16'h8000, 16'h0000));
        exp_q.push_back(mk_exp(1'b0, 16'h00F0, 16'h0F00));
        exp_q.push_back(mk_exp(1'b1, 16'h8000, 16'h0000));
        run_txn(1'b0, 16'h0FF0, 0, 1'b0);
        run_txn(1'b1, 16'h8000, 5, 1'b0);
        run_txn(1'b0, 16'h0FF0, 1, 1'b0);
        run_txn(1'b1, 16'h8000, 0, 1'b0);
        req0 = 1'b0; req1 = 1'b0;

        // zero flag from requester 1
        a1 = 16'h1234; b1 = 16'h1234; req1 = 1'b1;
        exp_q.push_back(mk_exp(1'b1, 16'h1234, 16'h1234));
        run_txn(1'b1, 16'h0000, 2, 1'b1);

        // reset during EXEC discards the operation
        a0 = 16'h00FF; b0 = 16'h0F0F; req0 = 1'b1;
        @(negedge clk);
        check("pre_reset_ack", 32'(ack0), 32'd1);
        #2;
        rst_n = 1'b0;
        req0 = 1'b0;
        #1;
        check("async_ack", 32'({ack0, ack1}), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_alu_a", alu_a, 32'd0);
        check("async_alu_b", alu_b, 32'd0);
        check("async_res_id", 32'(res_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_reset_quiet", 32'({res_valid, ack0, ack1, busy}), 32'd0);
        end

        // fresh operation still works after the abort
        req0 = 1'b1;
        exp_q.push_back(mk_exp(1'b0, 16'h00FF, 16'h0F0F));
        run_txn(1'b0, 16'h0FF0, 0, 1'b1);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
